// File: rtl/pixel_readout.sv
// Pixel array readout sequencer: scans every address, samples DATA after a
// programmable settle time and queues {addr, data} in a show-ahead FIFO.
module pixel_readout #(
  parameter int unsigned row_num    = 2,
  parameter int unsigned column_num = 2,
  parameter int unsigned bits       = 2,
  parameter int unsigned settle     = 2,
  parameter int unsigned fifo_depth = 4
) (
  input  logic            CLK,
  input  logic            RSTN,
  input  logic            START,
  output logic            BUSY,
  output logic            DONE,
  output logic            READ,
  output logic [bits-1:0] PIXELADDR,
  input  logic [7:0]      DATA,
  output logic [7:0]      OUT_DATA,
  output logic [bits-1:0] OUT_ADDR,
  output logic            OUT_VALID,
  input  logic            OUT_READY
);

  localparam int unsigned Pixels = row_num * column_num;
  localparam logic [bits-1:0] LastAddr = bits'(Pixels - 1);
  localparam int unsigned SW = (settle > 1) ? $clog2(settle) : 1;
  localparam int unsigned PW = $clog2(fifo_depth);
  localparam int unsigned EntryW = bits + 8;
  localparam logic [PW:0] FullCnt = (PW+1)'(fifo_depth);

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StGap} state_e;

  // READ is high for exactly `settle` cycles per pixel, the last being CAPTURE,
  // so with settle == 1 the SETTLE state is skipped entirely.
  localparam state_e StFirst = (settle == 1) ? StCapture : StSettle;

  state_e            state_q, state_d;
  logic [bits-1:0]   addr_q, addr_d;
  logic [SW-1:0]     scnt_q, scnt_d;
  logic              done_q, done_d;

  logic [EntryW-1:0] mem [fifo_depth];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [PW:0]       count_q;
  logic              full, push, pop;
  logic [EntryW-1:0] head;

  assign full = (count_q == FullCnt);
  assign push = (state_q == StCapture) && !full;
  assign pop  = OUT_VALID && OUT_READY;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    scnt_d  = scnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (START) begin
          state_d = StFirst;
          addr_d  = '0;
          scnt_d  = '0;
        end
      end
      StSettle: begin
        scnt_d = scnt_q + 1'b1;
        if (int'(scnt_d) == int'(settle) - 1) state_d = StCapture;
      end
      StCapture: begin
        if (!full) begin
          if (addr_q == LastAddr) begin
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            state_d = StGap;
            addr_d  = addr_q + 1'b1;
          end
        end
      end
      StGap: begin
        state_d = StFirst;
        scnt_d  = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= StIdle;
      addr_q  <= '0;
      scnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      scnt_q  <= scnt_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset; contents are only visible while OUT_VALID is high.
  always_ff @(posedge CLK) begin
    if (push) mem[wptr_q] <= {addr_q, DATA};
  end

  assign head      = mem[rptr_q];
  assign OUT_ADDR  = head[EntryW-1:8];
  assign OUT_DATA  = head[7:0];
  assign OUT_VALID = (count_q != '0);

  assign READ      = (state_q == StSettle) || (state_q == StCapture);
  assign BUSY      = (state_q != StIdle);
  assign DONE      = done_q;
  assign PIXELADDR = addr_q;

endmodule

// File: tb/tb_pixel_readout.sv
// Directed bench for pixel_readout: a 2x2/settle=2/depth=2 instance and a
// 3x3/settle=1 instance, with the array modelled as DATA = 8'h10 + PIXELADDR.
module tb_pixel_readout;

  logic       clk, rstn;
  logic       start_a, ready_a, busy_a, done_a, read_a, out_valid_a;
  logic [1:0] addr_a, out_addr_a;
  logic [7:0] data_a, out_data_a;
  logic       start_b, ready_b, busy_b, done_b, read_b, out_valid_b;
  logic [3:0] addr_b, out_addr_b;
  logic [7:0] data_b, out_data_b;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int pop_q_a[$];
  int pop_q_b[$];
  int done_cnt_a = 0;
  int done_cnt_b = 0;
  int max_b = 0;
  bit rd_log[64];
  bit dn_log[64];
  bit bz_log[64];
  bit rdb_log[64];
  bit dnb_log[64];
  int adb_log[64];

  pixel_readout #(.row_num(2), .column_num(2), .bits(2), .settle(2), .fifo_depth(2)) dut_a (
    .CLK(clk), .RSTN(rstn), .START(start_a), .BUSY(busy_a), .DONE(done_a), .READ(read_a),
    .PIXELADDR(addr_a), .DATA(data_a), .OUT_DATA(out_data_a), .OUT_ADDR(out_addr_a),
    .OUT_VALID(out_valid_a), .OUT_READY(ready_a)
  );

  pixel_readout #(.row_num(3), .column_num(3), .bits(4), .settle(1), .fifo_depth(2)) dut_b (
    .CLK(clk), .RSTN(rstn), .START(start_b), .BUSY(busy_b), .DONE(done_b), .READ(read_b),
    .PIXELADDR(addr_b), .DATA(data_b), .OUT_DATA(out_data_b), .OUT_ADDR(out_addr_b),
    .OUT_VALID(out_valid_b), .OUT_READY(ready_b)
  );

  assign data_a = read_a ? 8'h10 + 8'(addr_a) : 8'h00;
  assign data_b = read_b ? 8'h10 + 8'(addr_b) : 8'h00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pops are logged mid-cycle, where inputs are stable until the next edge.
  always @(negedge clk) begin
    if (out_valid_a && ready_a) pop_q_a.push_back(int'({out_addr_a, out_data_a}));
    if (out_valid_b && ready_b) pop_q_b.push_back(int'({out_addr_b, out_data_b}));
    if (done_a) done_cnt_a++;
    if (done_b) done_cnt_b++;
    if (int'(addr_b) > max_b) max_b = int'(addr_b);
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (cyc < 64) begin
      rd_log[cyc]  = read_a;
      dn_log[cyc]  = done_a;
      bz_log[cyc]  = busy_a;
      rdb_log[cyc] = read_b;
      dnb_log[cyc] = done_b;
      adb_log[cyc] = int'(addr_b);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_a_scan();
    start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    cyc = 1;
  endtask

  task automatic check_pops_a(input string tag, input int n);
    check({tag, "_count"}, pop_q_a.size(), n);
    for (int i = 0; i < n && i < pop_q_a.size(); i++)
      check($sformatf("%s_pop%0d", tag, i), pop_q_a[i], ((i % 4) << 8) | (8'h10 + (i % 4)));
  endtask

  initial begin
    rstn = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ready_a = 1'b1;
    ready_b = 1'b1;
    @(posedge clk);
    #1;
    check("rst_read", read_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_valid", out_valid_a, 0);
    check("rst_addr", addr_a, 0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Basic unstalled scan
    pop_q_a.delete();
    done_cnt_a = 0;
    start_a_scan();
    repeat (13) step();
    for (int c = 1; c <= 13; c++) begin
      check($sformatf("t1_read_c%0d", c), rd_log[c], int'((c % 3) != 0 && c < 12));
      check($sformatf("t1_done_c%0d", c), dn_log[c], int'(c == 12));
      check($sformatf("t1_busy_c%0d", c), bz_log[c], int'(c < 12));
    end
    check_pops_a("t1", 4);

    // Backpressure stall with a full FIFO
    pop_q_a.delete();
    done_cnt_a = 0;
    ready_a = 1'b0;
    start_a_scan();
    repeat (20) step();
    check("t2_stall_read", read_a, 1);
    check("t2_stall_addr", addr_a, 2);
    check("t2_stall_valid", out_valid_a, 1);
    check("t2_stall_busy", busy_a, 1);
    check("t2_stall_done", done_cnt_a, 0);
    ready_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (done_cnt_a == 1 && !out_valid_a) break;
    end
    check("t2_done_cnt", done_cnt_a, 1);
    check("t2_drained", out_valid_a, 0);
    check_pops_a("t2", 4);

    // START held during a scan is ignored
    pop_q_a.delete();
    done_cnt_a = 0;
    start_a_scan();
    step();
    start_a = 1'b1;
    repeat (9) step();
    start_a = 1'b0;
    repeat (4) step();
    check("t3_done_c12", dn_log[12], 1);
    check("t3_done_cnt", done_cnt_a, 1);
    check("t3_busy_c11", bz_log[11], 1);
    check("t3_busy_c12", bz_log[12], 0);
    check("t3_busy_c13", bz_log[13], 0);
    check_pops_a("t3", 4);

    // Second scan queues behind unpopped samples of the first
    pop_q_a.delete();
    done_cnt_a = 0;
    ready_a = 1'b0;
    start_a_scan();
    repeat (10) step();
    ready_a = 1'b1;
    repeat (2) step();
    ready_a = 1'b0;
    repeat (3) step();
    check("t3b_done_pulse", done_a, 1);
    check("t3b_leftover", out_valid_a, 1);
    start_a_scan();
    repeat (8) step();
    ready_a = 1'b1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (done_cnt_a == 2 && !out_valid_a) break;
    end
    check("t3b_done_cnt", done_cnt_a, 2);
    check_pops_a("t3b", 8);

    // Asynchronous reset mid-scan
    pop_q_a.delete();
    done_cnt_a = 0;
    ready_a = 1'b0;
    start_a_scan();
    repeat (4) step();
    check("t4_pre_valid", out_valid_a, 1);
    check("t4_pre_read", read_a, 1);
    #2;
    rstn = 1'b0;
    #1;
    check("t4_rst_read", read_a, 0);
    check("t4_rst_valid", out_valid_a, 0);
    check("t4_rst_busy", busy_a, 0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    repeat (3) step();
    check("t4_no_done", done_cnt_a, 0);
    ready_a = 1'b1;
    start_a_scan();
    check("t4_restart_read", read_a, 1);
    check("t4_restart_addr", addr_a, 0);
    repeat (15) step();
    check("t4_done_cnt", done_cnt_a, 1);
    check_pops_a("t4", 4);

    // 3x3 array, settle = 1
    pop_q_b.delete();
    done_cnt_b = 0;
    max_b = 0;
    start_b = 1'b1;
    @(posedge clk);
    #1;
    start_b = 1'b0;
    cyc = 1;
    repeat (20) step();
    for (int c = 1; c <= 19; c++) begin
      check($sformatf("t5_read_c%0d", c), rdb_log[c], int'((c % 2) == 1 && c < 18));
      if (c % 2 == 1 && c < 18) check($sformatf("t5_addr_c%0d", c), adb_log[c], (c - 1) / 2);
      check($sformatf("t5_done_c%0d", c), dnb_log[c], int'(c == 18));
    end
    check("t5_max_addr", max_b, 8);
    check("t5_done_cnt", done_cnt_b, 1);
    check("t5_pop_count", pop_q_b.size(), 9);
    for (int i = 0; i < 9 && i < pop_q_b.size(); i++)
      check($sformatf("t5_pop%0d", i), pop_q_b[i], (i << 8) | (8'h10 + i));

    // OUT_READY toggling every cycle
    pop_q_a.delete();
    done_cnt_a = 0;
    ready_a = 1'b1;
    start_a_scan();
    for (int i = 0; i < 40; i++) begin
      step();
      ready_a = ~ready_a;
      if (done_cnt_a == 1 && pop_q_a.size() >= 4) break;
    end
    ready_a = 1'b1;
    repeat (3) step();
    check("t6_done_cnt", done_cnt_a, 1);
    check("t6_drained", out_valid_a, 0);
    check_pops_a("t6", 4);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
